prio_arbiter: RTL and testbench

- Registered, parametrised N-input priority arbiter with run-time selectable policy: fixed-high, fixed-low, or round-robin.
- Successor to the combinational priority encoder. Adds a grant handshake, sticky grants, and fairness state.
- Sits between request sources (switches, debounced buttons, peripheral request lines) and a consumer such as the seven-segment index display or a shared-resource mux.

---
 rtl/prio_pkg.sv | 16 +
 rtl/prio_pick.sv | 46 ++++
 rtl/prio_arbiter.sv | 93 +++++++++
 tb/tb_prio_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared types for the priority arbiter: arbitration policy encoding and FSM states.
package prio_pkg;

  typedef enum logic [1:0] {
    PM_FIXED_HI = 2'b00,
    PM_FIXED_LO = 2'b01,
    PM_RR       = 2'b10,
    PM_RSVD     = 2'b11
  } prio_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } prio_state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search: fixed-high, fixed-low, or round-robin from start.
module prio_pick
  import prio_pkg::*;
#(
  parameter int N    = 16,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [1:0]      mode,
  input  logic [IDXW-1:0] start,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  localparam logic [IDXW:0] NW = (IDXW+1)'(N);

  prio_mode_t m;
  assign m = prio_mode_t'(mode);

  // Each loop lets the last hit win, so iteration order sets the priority.
  always_comb begin : search
    logic [IDXW:0] pos;
    found = |req;
    idx   = '0;
    pos   = '0;
    case (m)
      PM_FIXED_LO: begin
        for (int i = N-1; i >= 0; i--)
          if (req[i]) idx = IDXW'(i);
      end
      PM_RR: begin
        // Wrap modulo N (not 2^IDXW) so non-power-of-two N never aliases.
        for (int k = N-1; k >= 0; k--) begin
          pos = {1'b0, start} + (IDXW+1)'(k);
          if (pos >= NW) pos = pos - NW;
          if (req[pos[IDXW-1:0]]) idx = pos[IDXW-1:0];
        end
      end
      default: begin
        for (int i = 0; i < N; i++)
          if (req[i]) idx = IDXW'(i);
      end
    endcase
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-input priority arbiter with sticky grants, ack handshake and round-robin state.
module prio_arbiter
  import prio_pkg::*;
#(
  parameter int N    = 16,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic            ack,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N-1);

  prio_state_t     state_q, state_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            rr_held_q, rr_held_d;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;

  prio_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req   (req),
    .mode  (mode),
    .start (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    rr_ptr_d     = rr_ptr_q;
    rr_held_d    = rr_held_q;
    case (state_q)
      ST_IDLE: begin
        if (en && pick_found) begin
          state_d                = ST_GRANT;
          gnt_valid_d            = 1'b1;
          gnt_idx_d              = pick_idx;
          gnt_onehot_d           = '0;
          gnt_onehot_d[pick_idx] = 1'b1;
          rr_held_d              = (mode == PM_RR);
        end
      end
      ST_GRANT: begin
        // Grant is sticky: only ack releases it, whatever req/en/mode do.
        if (ack) begin
          state_d      = ST_IDLE;
          gnt_valid_d  = 1'b0;
          gnt_onehot_d = '0;
          if (rr_held_q)
            rr_ptr_d = (gnt_idx_q == LAST) ? '0 : gnt_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      rr_ptr_q     <= '0;
      rr_held_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      rr_ptr_q     <= rr_ptr_d;
      rr_held_q    <= rr_held_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Scoreboard bench for prio_arbiter: a 16-input and a 5-input instance.
module tb_prio_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_req;
  logic        a_en, a_ack;
  logic [1:0]  a_mode;
  logic        a_gnt_valid;
  logic [3:0]  a_gnt_idx;
  logic [15:0] a_gnt_onehot;

  logic [4:0]  b_req;
  logic        b_en, b_ack;
  logic [1:0]  b_mode;
  logic        b_gnt_valid;
  logic [2:0]  b_gnt_idx;
  logic [4:0]  b_gnt_onehot;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  prio_arbiter #(.N(16)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .en(a_en), .mode(a_mode), .ack(a_ack),
    .gnt_valid(a_gnt_valid), .gnt_idx(a_gnt_idx), .gnt_onehot(a_gnt_onehot)
  );

  prio_arbiter #(.N(5)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .en(b_en), .mode(b_mode), .ack(b_ack),
    .gnt_valid(b_gnt_valid), .gnt_idx(b_gnt_idx), .gnt_onehot(b_gnt_onehot)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant on instance A, then checks it against the queue head.
  task automatic pop_a(input string tag);
    bit ok = 0;
    int e;
    logic [15:0] oh;
    for (int i = 0; i < 8; i++) begin
      if (a_gnt_valid) begin ok = 1; break; end
      step();
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    e  = exp_q.pop_front();
    oh = 16'd1 << e;
    chk({tag, "_idx"}, 32'(a_gnt_idx), 32'(e));
    chk({tag, "_oh"}, 32'(a_gnt_onehot), 32'(oh));
  endtask

  task automatic ack_a(input string tag);
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    chk({tag, "_rel"}, {31'd0, a_gnt_valid}, 32'd0);
    chk({tag, "_reloh"}, 32'(a_gnt_onehot), 32'd0);
  endtask

  // One-edge request pulse on A, expected winner queued at drive time.
  task automatic grant_a(input string tag, input logic [15:0] r, input logic [1:0] m, input int e);
    a_req = r; a_mode = m; a_en = 1'b1;
    exp_q.push_back(e);
    step();
    a_req = '0;
    pop_a(tag);
  endtask

  initial begin
    rst = 1'b1;
    a_req = '0; a_en = 1'b0; a_mode = 2'b00; a_ack = 1'b0;
    b_req = '0; b_en = 1'b0; b_mode = 2'b00; b_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, a_gnt_valid}, 32'd0);
    chk("rst_idx", 32'(a_gnt_idx), 32'd0);
    chk("rst_oh", 32'(a_gnt_onehot), 32'd0);

    // Fixed-high grant held until ack, then fixed-low and reserved mode
    grant_a("fhi", 16'h0A10, 2'b00, 11);
    step(); step();
    chk("fhi_hold_v", {31'd0, a_gnt_valid}, 32'd1);
    chk("fhi_hold_idx", 32'(a_gnt_idx), 32'd11);
    ack_a("fhi");
    step();
    grant_a("flo", 16'h0A10, 2'b01, 4);
    ack_a("flo");
    step();
    grant_a("rsvd", 16'h0A10, 2'b11, 11);
    ack_a("rsvd");
    chk("fixed_ptr", 32'(dut_a.rr_ptr_q), 32'd0);

    // Round-robin alternation with req held
    a_mode = 2'b10; a_en = 1'b1; a_req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k % 2 == 0) ? 0 : 15);
      pop_a("rr16");
      ack_a("rr16");
      chk("rr16_ptr", 32'(dut_a.rr_ptr_q), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    a_req = '0;
    step();

    // Stickiness: req, en, mode wander while ack stays low
    grant_a("stk", 16'h0080, 2'b00, 7);
    for (int k = 0; k < 10; k++) begin
      a_en   = k[0];
      a_mode = 2'(k);
      step();
      chk("stk_v", {31'd0, a_gnt_valid}, 32'd1);
      chk("stk_idx", 32'(a_gnt_idx), 32'd7);
    end
    ack_a("stk");
    a_en = 1'b0; a_req = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en_off", {31'd0, a_gnt_valid}, 32'd0);
    end
    a_req = '0;
    chk("stk_ptr", 32'(dut_a.rr_ptr_q), 32'd0);

    // Reset mid-grant with rr_ptr=9
    grant_a("rr8", 16'h0100, 2'b10, 8);
    ack_a("rr8");
    chk("rr8_ptr", 32'(dut_a.rr_ptr_q), 32'd9);
    step();
    grant_a("rr_wrap", 16'h0008, 2'b10, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_v", {31'd0, a_gnt_valid}, 32'd0);
    chk("mid_rst_oh", 32'(a_gnt_onehot), 32'd0);
    chk("mid_rst_idx", 32'(a_gnt_idx), 32'd0);
    chk("mid_rst_ptr", 32'(dut_a.rr_ptr_q), 32'd0);
    grant_a("post_rst", 16'hFFFF, 2'b10, 0);
    ack_a("post_rst");

    // N=5 round-robin wrap modulo N
    b_mode = 2'b10; b_en = 1'b1; b_req = 5'b10001;
    for (int k = 0; k < 3; k++) begin
      bit ok = 0;
      int e;
      exp_q.push_back((k == 1) ? 4 : 0);
      for (int i = 0; i < 8; i++) begin
        if (b_gnt_valid) begin ok = 1; break; end
        step();
      end
      chk("rr5_seen", 32'(ok), 32'd1);
      e = exp_q.pop_front();
      chk("rr5_idx", 32'(b_gnt_idx), 32'(e));
      chk("rr5_oh", 32'(b_gnt_onehot), 32'(5'd1 << e));
      b_ack = 1'b1;
      step();
      b_ack = 1'b0;
      chk("rr5_rel", {31'd0, b_gnt_valid}, 32'd0);
      chk("rr5_ptr", 32'(dut_b.rr_ptr_q), (k == 1) ? 32'd0 : 32'd1);
    end
    b_req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
